pattern_bist_ctrl: RTL
======================

# pattern_bist_ctrl

Built-in self-test driver/compactor for generated merged-pattern netlists. Drives the netlist's primary inputs from a maximal-length LFSR. Compacts the netlist's primary outputs into a MISR signature. Reports pass/fail against a golden signature. It is the stimulus/response end of the combinational netlist interface: the netlist consumes `stim_out`, and this block consumes the netlist's outputs on `resp_in`.

## Interface
- `IN_W`, 11 — stimulus width; bit i drives the netlist's i-th primary input, in declaration order.
- `OUT_W`, 10 — response width; bit i is the netlist's i-th primary output, in declaration order.
- `NUM_PAT`, 256 — patterns per run; range 1..65535.
- `SETTLE`, 1 — cycles each pattern is held before capture; range 1..15.
- `SEED`, 11'h001 — LFSR load value; all-zero is replaced by 1.
- `blif_clk_net  in  1` — single clock, rising edge.
- `blif_reset_net  in  1` — asynchronous, active-high reset.
- `start  in  1` — run request, sampled in IDLE or DONE.
- `abort  in  1` — synchronous run cancel.
- `golden_sig  in  OUT_W` — expected signature; must be stable while `done`=1.
- `resp_in  in  OUT_W` — netlist response to `stim_out`.
- `stim_out  out  IN_W` — registered stimulus.
- `busy  out  1` — high in LOAD/APPLY/CAPTURE.
- `done  out  1` — high in DONE.
- `pass  out  1` — `signature == golden_sig`; qualified by `done`, 0 otherwise.
- `signature  out  OUT_W` — MISR contents.

## Operation
- States are IDLE, LOAD, APPLY, CAPTURE, DONE.
- **IDLE:**
  - `start` → LOAD.
  - `stim_out`=0.
- **LOAD** (1 cycle):
  - lfsr←SEED, misr←0, pat_cnt←0, settle_cnt←0.
  - → APPLY.
- **APPLY:**
  - `stim_out`=lfsr.
  - settle_cnt increments each cycle.
  - When settle_cnt==SETTLE-1, → CAPTURE.
- **CAPTURE** (1 cycle):
  - misr←misr_next(resp_in).
  - lfsr←lfsr_next.
  - settle_cnt←0.
  - If pat_cnt==NUM_PAT-1, → DONE; else pat_cnt++ and → APPLY.
- **DONE:**
  - `stim_out` holds the last value.
  - `signature` holds.
  - `start` → LOAD (restart); otherwise stay.
- **abort:** in any state except IDLE → IDLE next cycle. It clears `stim_out`, `busy` and `done`; `signature` keeps its value. `abort` has priority over `start` and over all transitions.
- **LFSR** (Fibonacci, x^11+x^9+1, period 2047): lfsr_next = {lfsr[9:0], lfsr[10]^lfsr[8]}.
- **MISR** (x^10+x^7+1):
  - next[0] = m[9]^m[6]^r[0].
  - next[i] = m[i-1]^r[i] for i=1..9.
  - For other widths the tap constants come from the package.
- **Counter widths:** pat_cnt is 16 bits; settle_cnt is 4 bits. No wrap occurs within legal parameter ranges.

## Timing
- **Reset values:**
  - `stim_out`=0, `signature`=0, `busy`=0, `done`=0, `pass`=0.
  - State IDLE; lfsr=SEED.
- **Start latency:** `start` high at edge k → `busy`=1 from k+1 (LOAD). The first pattern appears on `stim_out` at k+2.
- **Run length:** `busy` lasts exactly 1 + NUM_PAT×(SETTLE+1) cycles; `done` rises the cycle after the last CAPTURE.
- **Response path:** `resp_in` is sampled only at the CAPTURE edge. The netlist path is therefore stim register → netlist → MISR, and must close in SETTLE+1 cycles (multicycle when SETTLE>1).
- **Pattern hold:** each stimulus value is held for SETTLE+1 cycles.
- **Boundary cases:**
  - `start` while busy: ignored.
  - `start` and `abort` in the same cycle: abort wins.
  - Reset mid-run: immediate return to reset values, with no partial DONE.
  - NUM_PAT=1: exactly one CAPTURE, then DONE.

## Structure
- Package `pattern_bist_pkg` holds:
  - state enum `bist_state_t`;
  - LFSR tap constants `LFSR_TAP_HI`/`LFSR_TAP_LO` (10, 8);
  - MISR tap constants (9, 6);
  - the zero-seed substitute value.
- Sub-module `pattern_misr` (OUT_W-wide, clear/enable ports) for reuse by other netlist benches.
- The LFSR and FSM stay in the top level.

## Test plan
- **Stimulus sequence:** NUM_PAT=12, SETTLE=1, SEED=001. `stim_out` steps through 001,002,004,008,010,020,040,080,100,201,402,005, each held for 2 cycles.
- **Zero response:** NUM_PAT=4, `resp_in`=0, `golden_sig`=0. Then `signature`=000, `done`=1, `pass`=1, and `busy` was high for 9 cycles.
- **Constant response:** NUM_PAT=3, SETTLE=2, `resp_in`=10'h001. Then `signature` goes 001, 003, 007, and `pass`=0 against golden 000.
- **Abort:** `abort` during the second APPLY. Next cycle: IDLE, `stim_out`=0, `busy`=0, `done`=0. A following `start` reproduces the first-pattern sequence from SEED.
- **Reset mid-run:** assert `blif_reset_net` asynchronously between edges. All outputs go to 0 without waiting for a clock edge; after release, `start` gives a full correct run.
- **Restart and zero seed:** `start` in DONE restarts the run (misr cleared; the new signature equals the previous one for the same `resp_in`). With SEED=0 the first stimulus is 001.

Source files
------------

// File: rtl/pattern_bist_pkg.sv
// ---------------------------------------------------------------------------
// pattern_bist_pkg
// Shared definitions for the merged-pattern netlist BIST controller:
//   - FSM state encodings (legacy-compatible localparam constants) and the
//     bist_state_t enum built from them
//   - LFSR feedback taps (x^11 + x^9 + 1)
//   - MISR feedback taps (x^10 + x^7 + 1)
//   - substitute seed used when the configured seed is all-zero
// ---------------------------------------------------------------------------
package pattern_bist_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD    = 3'd1;
  localparam logic [2:0] ST_APPLY   = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  typedef enum logic [2:0] {
    BIST_IDLE    = ST_IDLE,
    BIST_LOAD    = ST_LOAD,
    BIST_APPLY   = ST_APPLY,
    BIST_CAPTURE = ST_CAPTURE,
    BIST_DONE    = ST_DONE
  } bist_state_t;

  // Fibonacci LFSR: new bit = lfsr[HI] ^ lfsr[LO], shifted in at bit 0.
  localparam int LFSR_TAP_HI = 10;
  localparam int LFSR_TAP_LO = 8;

  // MISR: bit 0 takes m[HI] ^ m[LO] ^ r[0]; the rest shift up with r[i].
  localparam int MISR_TAP_HI = 9;
  localparam int MISR_TAP_LO = 6;

  // An all-zero LFSR is a lock-up state, so a zero seed is replaced by this.
  localparam int ZERO_SEED_SUB = 1;

endpackage

// File: rtl/pattern_misr.sv
// ---------------------------------------------------------------------------
// pattern_misr
// Multiple-input signature register compacting an OUT_W-wide response word
// per enabled cycle. Reusable by other netlist benches.
// Ports:
//   clk   in  1      rising-edge clock
//   rst   in  1      asynchronous active-high reset (signature -> 0)
//   clr   in  1      synchronous clear (signature -> 0), priority over en
//   en    in  1      compact resp into the signature this cycle
//   resp  in  OUT_W  response word
//   sig   out OUT_W  current signature
// ---------------------------------------------------------------------------
module pattern_misr
  import pattern_bist_pkg::*;
#(
  parameter int OUT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [OUT_W-1:0] resp,
  output logic [OUT_W-1:0] sig
);

  function automatic logic [OUT_W-1:0] misr_next(input logic [OUT_W-1:0] m,
                                                 input logic [OUT_W-1:0] r);
    logic [OUT_W-1:0] shifted;
    shifted = {m[OUT_W-2:0], m[MISR_TAP_HI] ^ m[MISR_TAP_LO]};
    return shifted ^ r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= misr_next(sig, resp);
    end
  end

endmodule

// File: rtl/pattern_bist_ctrl.sv
// ---------------------------------------------------------------------------
// pattern_bist_ctrl
// BIST driver/compactor for a generated combinational netlist. An LFSR
// supplies registered stimulus; the netlist response is folded into a MISR
// once per pattern and compared against a golden signature at the end.
// Ports:
//   blif_clk_net    in  1      clock, rising edge
//   blif_reset_net  in  1      asynchronous active-high reset
//   start           in  1      run request (honoured in IDLE or DONE)
//   abort           in  1      synchronous cancel, wins over everything
//   golden_sig      in  OUT_W  expected signature
//   resp_in         in  OUT_W  netlist response to stim_out
//   stim_out        out IN_W   registered stimulus
//   busy            out 1      LOAD / APPLY / CAPTURE
//   done            out 1      DONE
//   pass            out 1      done && signature == golden_sig
//   signature       out OUT_W  MISR contents
// ---------------------------------------------------------------------------
module pattern_bist_ctrl
  import pattern_bist_pkg::*;
#(
  parameter int              IN_W    = 11,
  parameter int              OUT_W   = 10,
  parameter int              NUM_PAT = 256,
  parameter int              SETTLE  = 1,
  parameter logic [IN_W-1:0] SEED    = 11'h001
) (
  input  logic             blif_clk_net,
  input  logic             blif_reset_net,
  input  logic             start,
  input  logic             abort,
  input  logic [OUT_W-1:0] golden_sig,
  input  logic [OUT_W-1:0] resp_in,
  output logic [IN_W-1:0]  stim_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [OUT_W-1:0] signature
);

  localparam logic [IN_W-1:0] SEED_EFF    = (SEED == '0) ? IN_W'(ZERO_SEED_SUB) : SEED;
  localparam logic [15:0]     PAT_LAST    = 16'(NUM_PAT - 1);
  localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);

  bist_state_t     state;
  bist_state_t     state_nxt;
  logic [IN_W-1:0] lfsr;
  logic [IN_W-1:0] lfsr_next;
  logic [15:0]     pat_cnt;
  logic [3:0]      settle_cnt;
  logic            misr_clr;
  logic            misr_en;

  assign lfsr_next = {lfsr[IN_W-2:0], lfsr[LFSR_TAP_HI] ^ lfsr[LFSR_TAP_LO]};

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_nxt = state;
    unique case (state)
      BIST_IDLE:    if (start) state_nxt = BIST_LOAD;
      BIST_LOAD:    state_nxt = BIST_APPLY;
      BIST_APPLY:   if (settle_cnt == SETTLE_LAST) state_nxt = BIST_CAPTURE;
      BIST_CAPTURE: state_nxt = (pat_cnt == PAT_LAST) ? BIST_DONE : BIST_APPLY;
      BIST_DONE:    if (start) state_nxt = BIST_LOAD;
      default:      state_nxt = BIST_IDLE;
    endcase
    if (abort) state_nxt = BIST_IDLE;
  end

  // Stimulus and counters. stim_out is loaded with each new LFSR value at
  // the edge that enters APPLY, so a pattern is held through its APPLY
  // cycles and its CAPTURE cycle. On the final CAPTURE the LFSR still
  // advances but stim_out keeps the last pattern for the DONE state.
  always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
    if (blif_reset_net) begin
      state      <= BIST_IDLE;
      lfsr       <= SEED_EFF;
      stim_out   <= '0;
      pat_cnt    <= '0;
      settle_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (abort) begin
        stim_out <= '0;
      end else begin
        unique case (state)
          BIST_LOAD: begin
            lfsr       <= SEED_EFF;
            stim_out   <= SEED_EFF;
            pat_cnt    <= '0;
            settle_cnt <= '0;
          end
          BIST_APPLY: begin
            settle_cnt <= settle_cnt + 4'd1;
          end
          BIST_CAPTURE: begin
            lfsr       <= lfsr_next;
            settle_cnt <= '0;
            if (pat_cnt != PAT_LAST) begin
              pat_cnt  <= pat_cnt + 16'd1;
              stim_out <= lfsr_next;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // resp_in is consumed only on the CAPTURE edge, giving the netlist
  // SETTLE+1 cycles from the stimulus register.
  assign misr_clr = (state == BIST_LOAD) && !abort;
  assign misr_en  = (state == BIST_CAPTURE) && !abort;

  pattern_misr #(
    .OUT_W (OUT_W)
  ) u_misr (
    .clk  (blif_clk_net),
    .rst  (blif_reset_net),
    .clr  (misr_clr),
    .en   (misr_en),
    .resp (resp_in),
    .sig  (signature)
  );

  assign busy = (state == BIST_LOAD) || (state == BIST_APPLY) || (state == BIST_CAPTURE);
  assign done = (state == BIST_DONE);
  assign pass = done && (signature == golden_sig);

endmodule
